mailbox: RTL and testbench

MAILBOX -- requirements
Module: mailbox

---
 rtl/mailbox.sv | 277 +++++++++++++++++++++++++++
 tb/tb_mailbox.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mailbox.sv
// -----------------------------------------------------------------------------
// mailbox
//
// Two-hart mailbox on a simple request/response bus. FIFO01 carries words from
// hart 0 to hart 1, FIFO10 carries words from hart 1 to hart 0. A status
// register, a 2-bit interrupt enable and a test-and-set semaphore complete the
// register map (word offsets, addr_i[9:2]):
//   0x00 TX01   write pushes FIFO01
//   0x04 RX01   read pops FIFO01
//   0x08 TX10   write pushes FIFO10
//   0x0C RX10   read pops FIFO10
//   0x10 STATUS read-only: [3:0] count01, [7:4] count10, [8] full01,
//               [9] empty01, [10] full10, [11] empty10
//   0x14 IRQ_EN read/write, bits [1:0]
//   0x18 SEMA   read returns the bit and sets it; write loads it
//
// Bus handshake: a request is accepted in every cycle in which req_i=1 (no
// stall path exists). Exactly one cycle later rvalid_o=1 together with
// rdata_o and err_o. When no response is due all three are 0.
//
// Ports
//   clk_i     single clock, rising edge
//   rst_i     synchronous active-high reset
//   req_i     request (always granted)
//   we_i      1 = write, 0 = read
//   be_i      byte enables (only be_i[0] matters, for IRQ_EN and SEMA writes)
//   addr_i    byte address, only [9:2] decoded
//   wdata_i   write data
//   rvalid_o  response valid
//   rdata_o   read data
//   err_o     error response
//   irq_o     level interrupts: [0] -> hart 0, [1] -> hart 1
//
// Depth must be 2, 4 or 8; DataWidth must be at least 12 so STATUS fits.
// -----------------------------------------------------------------------------
module mailbox #(
  parameter int Depth     = 4,
  parameter int DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [3:0]           be_i,
  input  logic [31:0]          addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic                 rvalid_o,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 err_o,
  output logic [1:0]           irq_o
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;

  // Word offsets (addr_i[9:2])
  localparam logic [7:0] OFF_TX01   = 8'h00;
  localparam logic [7:0] OFF_RX01   = 8'h01;
  localparam logic [7:0] OFF_TX10   = 8'h02;
  localparam logic [7:0] OFF_RX10   = 8'h03;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_IRQ_EN = 8'h05;
  localparam logic [7:0] OFF_SEMA   = 8'h06;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DataWidth-1:0] r_mem01 [Depth];
  logic [DataWidth-1:0] r_mem10 [Depth];
  logic [PtrW-1:0]      r_wptr01;
  logic [PtrW-1:0]      r_rptr01;
  logic [CntW-1:0]      r_cnt01;
  logic [PtrW-1:0]      r_wptr10;
  logic [PtrW-1:0]      r_rptr10;
  logic [CntW-1:0]      r_cnt10;
  logic [1:0]           r_irq_en;
  logic                 r_sema;

  logic                 r_rvalid;
  logic [DataWidth-1:0] r_rdata;
  logic                 r_err;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [7:0]  w_off;
  logic        w_full01;
  logic        w_empty01;
  logic        w_full10;
  logic        w_empty10;
  logic        w_push01;
  logic        w_pop01;
  logic        w_push10;
  logic        w_pop10;
  logic        w_irq_en_wr;
  logic        w_sema_wr;
  logic        w_sema_rd;
  logic [31:0] w_status;

  assign w_off = addr_i[9:2];

  assign w_full01  = (r_cnt01 == CntW'(Depth));
  assign w_empty01 = (r_cnt01 == '0);
  assign w_full10  = (r_cnt10 == CntW'(Depth));
  assign w_empty10 = (r_cnt10 == '0);

  // Push/pop fire only when they can succeed; a refused push or pop leaves
  // the FIFO untouched and is reported through err_o instead.
  assign w_push01 = req_i && we_i  && (w_off == OFF_TX01) && !w_full01;
  assign w_pop01  = req_i && !we_i && (w_off == OFF_RX01) && !w_empty01;
  assign w_push10 = req_i && we_i  && (w_off == OFF_TX10) && !w_full10;
  assign w_pop10  = req_i && !we_i && (w_off == OFF_RX10) && !w_empty10;

  assign w_irq_en_wr = req_i && we_i  && (w_off == OFF_IRQ_EN) && be_i[0];
  assign w_sema_wr   = req_i && we_i  && (w_off == OFF_SEMA)   && be_i[0];
  assign w_sema_rd   = req_i && !we_i && (w_off == OFF_SEMA);

  always_comb begin
    w_status        = 32'd0;
    w_status[3:0]   = 4'(r_cnt01);
    w_status[7:4]   = 4'(r_cnt10);
    w_status[8]     = w_full01;
    w_status[9]     = w_empty01;
    w_status[10]    = w_full10;
    w_status[11]    = w_empty10;
  end

  // Address bits outside the 1 kB word window and the upper byte enables have
  // no function in this block.
  logic w_unused;
  assign w_unused = ^{addr_i[31:10], addr_i[1:0], be_i[3:1]};

  // ---------------------------------------------------------------------------
  // Pointer increment with explicit wrap from Depth-1 back to 0
  // ---------------------------------------------------------------------------
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(Depth - 1)) begin
      return '0;
    end
    return p + PtrW'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // FIFO storage (not reset; pointers and counts define what is valid)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (w_push01) begin
      r_mem01[r_wptr01] <= wdata_i;
    end
    if (w_push10) begin
      r_mem10[r_wptr10] <= wdata_i;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers and counts. Only one request per cycle exists, so a FIFO
  // never sees a push and a pop in the same cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr01 <= '0;
      r_rptr01 <= '0;
      r_cnt01  <= '0;
      r_wptr10 <= '0;
      r_rptr10 <= '0;
      r_cnt10  <= '0;
    end else begin
      if (w_push01) begin
        r_wptr01 <= ptr_inc(r_wptr01);
        r_cnt01  <= r_cnt01 + CntW'(1);
      end
      if (w_pop01) begin
        r_rptr01 <= ptr_inc(r_rptr01);
        r_cnt01  <= r_cnt01 - CntW'(1);
      end
      if (w_push10) begin
        r_wptr10 <= ptr_inc(r_wptr10);
        r_cnt10  <= r_cnt10 + CntW'(1);
      end
      if (w_pop10) begin
        r_rptr10 <= ptr_inc(r_rptr10);
        r_cnt10  <= r_cnt10 - CntW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // IRQ enable and semaphore
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_irq_en <= 2'b00;
      r_sema   <= 1'b0;
    end else begin
      if (w_irq_en_wr) begin
        r_irq_en <= wdata_i[1:0];
      end
      // Test-and-set: the read response carries the old value (captured in
      // the response mux below) while the bit becomes 1 at this edge.
      if (w_sema_rd) begin
        r_sema <= 1'b1;
      end else if (w_sema_wr) begin
        r_sema <= wdata_i[0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response generation. Everything is computed from state as it stands
  // before this cycle's edge, so STATUS reflects all earlier accesses.
  // ---------------------------------------------------------------------------
  logic [DataWidth-1:0] w_rsp_data;
  logic                 w_rsp_err;

  always_comb begin
    w_rsp_data = '0;
    w_rsp_err  = 1'b0;
    if (req_i) begin
      case (w_off)
        OFF_TX01: begin
          if (we_i && w_full01) w_rsp_err = 1'b1;
        end
        OFF_RX01: begin
          if (!we_i) begin
            if (w_empty01) w_rsp_err  = 1'b1;
            else           w_rsp_data = r_mem01[r_rptr01];
          end
        end
        OFF_TX10: begin
          if (we_i && w_full10) w_rsp_err = 1'b1;
        end
        OFF_RX10: begin
          if (!we_i) begin
            if (w_empty10) w_rsp_err  = 1'b1;
            else           w_rsp_data = r_mem10[r_rptr10];
          end
        end
        OFF_STATUS: begin
          if (!we_i) w_rsp_data = DataWidth'(w_status);
        end
        OFF_IRQ_EN: begin
          if (!we_i) w_rsp_data = DataWidth'({30'd0, r_irq_en});
        end
        OFF_SEMA: begin
          if (!we_i) w_rsp_data = DataWidth'({31'd0, r_sema});
        end
        default: begin
          w_rsp_err = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= req_i;
      r_rdata  <= w_rsp_data;
      r_err    <= w_rsp_err;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Gating with rst_i squashes the response to a request accepted in
  // the cycle just before reset, and holds irq_o low for the whole reset.
  // ---------------------------------------------------------------------------
  assign rvalid_o = r_rvalid && !rst_i;
  assign rdata_o  = rst_i ? '0 : r_rdata;
  assign err_o    = r_err && !rst_i;

  assign irq_o[0] = !rst_i && r_irq_en[0] && !w_empty10;
  assign irq_o[1] = !rst_i && r_irq_en[1] && !w_empty01;

endmodule

// File: tb/tb_mailbox.sv
// -----------------------------------------------------------------------------
// tb_mailbox
//
// Directed bench for mailbox (Depth=4, DataWidth=32). Each bus access pushes
// its expected {err, rdata} into exp_q; the monitor on the falling edge pops
// and compares whenever rvalid_o is high, checks idle outputs are 0 otherwise,
// and checks all outputs are 0 while reset is held. irq_o is checked directly
// one step after the edge that accepted the causing access.
// -----------------------------------------------------------------------------
module tb_mailbox;

  localparam int DW = 32;

  localparam logic [31:0] A_TX01   = 32'h00;
  localparam logic [31:0] A_RX01   = 32'h04;
  localparam logic [31:0] A_TX10   = 32'h08;
  localparam logic [31:0] A_RX10   = 32'h0C;
  localparam logic [31:0] A_STATUS = 32'h10;
  localparam logic [31:0] A_IRQ_EN = 32'h14;
  localparam logic [31:0] A_SEMA   = 32'h18;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req;
  logic          we;
  logic [3:0]    be;
  logic [31:0]   addr;
  logic [DW-1:0] wdata;
  logic          rvalid;
  logic [DW-1:0] rdata;
  logic          err;
  logic [1:0]    irq;

  mailbox #(.Depth(4), .DataWidth(DW)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req),
    .we_i     (we),
    .be_i     (be),
    .addr_i   (addr),
    .wdata_i  (wdata),
    .rvalid_o (rvalid),
    .rdata_o  (rdata),
    .err_o    (err),
    .irq_o    (irq)
  );

  // Scoreboard
  logic [DW:0] exp_q[$];
  logic [DW:0] mon_exp;
  int checks = 0;
  int errors = 0;

  // Driver tasks: present a request, record its expected response, hold it
  // across one rising edge. Consecutive calls give back-to-back requests.
  task automatic bus(input logic we_v, input logic [31:0] addr_v,
                     input logic [31:0] wdata_v, input logic [3:0] be_v,
                     input logic [31:0] exp_data, input logic exp_err);
    req   = 1'b1;
    we    = we_v;
    addr  = addr_v;
    wdata = wdata_v;
    be    = be_v;
    exp_q.push_back({exp_err, exp_data});
    @(posedge clk);
    #1;
    req   = 1'b0;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
    be    = '0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic e);
    bus(1'b1, a, d, 4'hF, 32'd0, e);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic e);
    bus(1'b0, a, 32'd0, 4'h0, d, e);
  endtask

  task automatic check_irq(input logic [1:0] exp_irq, input string name);
    checks++;
    if (irq !== exp_irq) begin
      errors++;
      $display("FAIL %s irq_o got %b expected %b at %0t", name, irq, exp_irq, $time);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      checks++;
      if (rvalid !== 1'b0 || rdata !== '0 || err !== 1'b0 || irq !== 2'b00) begin
        errors++;
        $display("FAIL reset_outputs got rvalid=%b rdata=%h err=%b irq=%b expected all 0 at %0t",
                 rvalid, rdata, err, irq, $time);
      end
    end else if (rvalid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp got rdata=%h err=%b with no request outstanding at %0t",
                 rdata, err, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({err, rdata} !== mon_exp) begin
          errors++;
          $display("FAIL response got err=%b rdata=%h expected err=%b rdata=%h at %0t",
                   err, rdata, mon_exp[DW], mon_exp[DW-1:0], $time);
        end
      end
    end else begin
      checks++;
      if (rvalid !== 1'b0 || rdata !== '0 || err !== 1'b0) begin
        errors++;
        $display("FAIL idle_outputs got rvalid=%b rdata=%h err=%b expected 0 at %0t",
                 rvalid, rdata, err, $time);
      end
    end
  end

  initial begin
    rst   = 1'b1;
    req   = 1'b0;
    we    = 1'b0;
    be    = '0;
    addr  = '0;
    wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state: both FIFOs empty
    check_irq(2'b00, "irq_after_reset");
    rd(A_STATUS, 32'h0000_0A00, 1'b0);

    // Ordering through FIFO01
    wr(A_TX01, 32'hA1, 1'b0);
    wr(A_TX01, 32'hA2, 1'b0);
    wr(A_TX01, 32'hA3, 1'b0);
    rd(A_STATUS, 32'h0000_0803, 1'b0);
    rd(A_RX01, 32'hA1, 1'b0);
    rd(A_RX01, 32'hA2, 1'b0);
    rd(A_RX01, 32'hA3, 1'b0);
    rd(A_RX01, 32'h0, 1'b1);
    rd(A_STATUS, 32'h0000_0A00, 1'b0);

    // Full and wrap on FIFO10. STATUS: count10=4, full10, and empty01 is set
    // because FIFO01 holds nothing.
    wr(A_TX10, 32'hB0, 1'b0);
    wr(A_TX10, 32'hB1, 1'b0);
    wr(A_TX10, 32'hB2, 1'b0);
    wr(A_TX10, 32'hB3, 1'b0);
    wr(A_TX10, 32'hB4, 1'b1);
    rd(A_STATUS, 32'h0000_0640, 1'b0);
    rd(A_RX10, 32'hB0, 1'b0);
    rd(A_RX10, 32'hB1, 1'b0);
    wr(A_TX10, 32'hB5, 1'b0);
    wr(A_TX10, 32'hB6, 1'b0);
    rd(A_STATUS, 32'h0000_0640, 1'b0);
    rd(A_RX10, 32'hB2, 1'b0);
    rd(A_RX10, 32'hB3, 1'b0);
    rd(A_RX10, 32'hB5, 1'b0);
    rd(A_RX10, 32'hB6, 1'b0);
    rd(A_RX10, 32'h0, 1'b1);

    // Interrupts
    wr(A_IRQ_EN, 32'h2, 1'b0);
    check_irq(2'b00, "irq_en_fifo_empty");
    rd(A_IRQ_EN, 32'h2, 1'b0);
    wr(A_TX01, 32'hC1, 1'b0);
    check_irq(2'b10, "irq1_after_push");
    rd(A_RX01, 32'hC1, 1'b0);
    check_irq(2'b00, "irq1_after_pop");
    wr(A_IRQ_EN, 32'h3, 1'b0);
    wr(A_TX10, 32'hD1, 1'b0);
    check_irq(2'b01, "irq0_after_push");
    rd(A_RX10, 32'hD1, 1'b0);
    check_irq(2'b00, "irq0_after_pop");

    // Semaphore
    rd(A_SEMA, 32'h0, 1'b0);
    rd(A_SEMA, 32'h1, 1'b0);
    wr(A_SEMA, 32'h0, 1'b0);
    rd(A_SEMA, 32'h0, 1'b0);
    bus(1'b1, A_SEMA, 32'h0, 4'hE, 32'h0, 1'b0);
    rd(A_SEMA, 32'h1, 1'b0);

    // Errors and side-effect-free accesses
    rd(32'h1C, 32'h0, 1'b1);
    wr(32'h20, 32'h5, 1'b1);
    rd(32'h3FC, 32'h0, 1'b1);
    bus(1'b1, A_IRQ_EN, 32'h0, 4'hE, 32'h0, 1'b0);
    rd(A_IRQ_EN, 32'h3, 1'b0);
    wr(A_IRQ_EN, 32'hFFFF_FFFF, 1'b0);
    rd(A_IRQ_EN, 32'h3, 1'b0);
    rd(A_TX01, 32'h0, 1'b0);
    rd(A_TX10, 32'h0, 1'b0);
    wr(A_RX01, 32'h77, 1'b0);
    wr(A_RX10, 32'h77, 1'b0);
    wr(A_STATUS, 32'hFFFF_FFFF, 1'b0);
    rd(A_STATUS, 32'h0000_0A00, 1'b0);

    // FIFO01 full, then drain to two entries
    wr(A_TX01, 32'hE0, 1'b0);
    wr(A_TX01, 32'hE1, 1'b0);
    wr(A_TX01, 32'hE2, 1'b0);
    wr(A_TX01, 32'hE3, 1'b0);
    wr(A_TX01, 32'hE4, 1'b1);
    rd(A_STATUS, 32'h0000_0904, 1'b0);
    check_irq(2'b10, "irq1_fifo01_full");
    rd(A_RX01, 32'hE0, 1'b0);
    rd(A_RX01, 32'hE1, 1'b0);
    rd(A_STATUS, 32'h0000_0802, 1'b0);

    // Reset mid-operation: a read of RX01 is accepted, then reset for one
    // cycle; its response must not appear (no expectation is queued).
    req  = 1'b1;
    we   = 1'b0;
    addr = A_RX01;
    @(posedge clk);
    #1;
    req  = 1'b0;
    addr = '0;
    rst  = 1'b1;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    check_irq(2'b00, "irq_after_mid_reset");
    rd(A_STATUS, 32'h0000_0A00, 1'b0);
    rd(A_IRQ_EN, 32'h0, 1'b0);
    rd(A_SEMA, 32'h0, 1'b0);
    wr(A_TX01, 32'hF1, 1'b0);
    rd(A_RX01, 32'hF1, 1'b0);

    // Drain and confirm every expected response arrived
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_rsp got %0d responses outstanding expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
